// File: rtl/game_flow_ctrl.sv
`timescale 1ns/1ps
// game_flow_ctrl
// Session controller for the brick-breaker game. Owns the game state machine
// (menu, play, pause, stage-clear interlude, win, lose), the stage index, the
// life and skill-point counters, the per-skill duration timers and the status
// LEDs. All outputs are registered.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   tick         one-cycle timebase enable; advances skill and clear timers
//   start_press  one-cycle start button pulse
//   pause_press  one-cycle pause button pulse
//   ball_lost    one-cycle pulse when the ball leaves through the bottom edge
//   bricks_clear level, high while the brick field is empty
//   skill_req    one-cycle request pulses for skills J/K/L (bit 0..2)
//   state        MENU=0 PLAY=1 PAUSE=2 STAGE_CLEAR=3 WIN=4 LOSE=5
//   stage_idx    current stage, 0-based
//   load_stage   one-cycle pulse on the first PLAY cycle of a stage
//   run          high only while in PLAY
//   life         remaining lives
//   skill_point  remaining skill points in this stage
//   skill_active per-skill active flags
//   led          life thermometer in the LSBs, skill thermometer in the MSBs
module game_flow_ctrl #(
   parameter int NUM_STAGES  = 3,
   parameter int LIVES       = 5,
   parameter int SKILL_MAX   = 3,
   parameter int SKILL_TICKS = 100,
   parameter int CLEAR_TICKS = 40,
   localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          start_press,
   input  logic          pause_press,
   input  logic          ball_lost,
   input  logic          bricks_clear,
   input  logic [2:0]    skill_req,
   output logic [2:0]    state,
   output logic [SW-1:0] stage_idx,
   output logic          load_stage,
   output logic          run,
   output logic [3:0]    life,
   output logic [2:0]    skill_point,
   output logic [2:0]    skill_active,
   output logic [15:0]   led
);

   localparam int MAX_TICKS = (SKILL_TICKS > CLEAR_TICKS) ? SKILL_TICKS : CLEAR_TICKS;
   localparam int TW        = $clog2(MAX_TICKS + 1);

   localparam logic [3:0]    LIVES_V    = 4'(LIVES);
   localparam logic [2:0]    SKILL_V    = 3'(SKILL_MAX);
   localparam logic [TW-1:0] SKILL_T    = TW'(SKILL_TICKS);
   localparam logic [TW-1:0] CLEAR_LAST = TW'(CLEAR_TICKS - 1);
   localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

   typedef enum logic [2:0] {
      MENU        = 3'd0,
      PLAY        = 3'd1,
      PAUSE       = 3'd2,
      STAGE_CLEAR = 3'd3,
      WIN         = 3'd4,
      LOSE        = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [SW-1:0]          stage_q, stage_d;
   logic [3:0]             life_q, life_d;
   logic [2:0]             skill_q, skill_d;
   logic [2:0]             active_q, active_d;
   logic [2:0][TW-1:0]     skill_tmr_q, skill_tmr_d;
   logic [TW-1:0]          clear_tmr_q, clear_tmr_d;
   logic                   load_q, load_d;
   logic                   run_q, run_d;
   logic [15:0]            led_q, led_d;
   logic                   granted;

   // Registers for the state machine and every output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= MENU;
         stage_q     <= '0;
         life_q      <= LIVES_V;
         skill_q     <= SKILL_V;
         active_q    <= '0;
         skill_tmr_q <= '0;
         clear_tmr_q <= '0;
         load_q      <= 1'b0;
         run_q       <= 1'b0;
         led_q       <= '0;
      end else begin
         state_q     <= state_d;
         stage_q     <= stage_d;
         life_q      <= life_d;
         skill_q     <= skill_d;
         active_q    <= active_d;
         skill_tmr_q <= skill_tmr_d;
         clear_tmr_q <= clear_tmr_d;
         load_q      <= load_d;
         run_q       <= run_d;
         led_q       <= led_d;
      end
   end

   // Next-state and counter logic. Skill timers only run in PLAY, which is
   // what freezes them during PAUSE. Any exit from PLAY other than PAUSE
   // drops all active skills and discards a grant made in the same cycle.
   always_comb begin
      state_d     = state_q;
      stage_d     = stage_q;
      life_d      = life_q;
      skill_d     = skill_q;
      active_d    = active_q;
      skill_tmr_d = skill_tmr_q;
      clear_tmr_d = clear_tmr_q;
      load_d      = 1'b0;
      granted     = 1'b0;

      case (state_q)
         MENU: begin
            if (start_press) begin
               state_d     = PLAY;
               stage_d     = '0;
               life_d      = LIVES_V;
               skill_d     = SKILL_V;
               active_d    = '0;
               skill_tmr_d = '0;
               clear_tmr_d = '0;
               load_d      = 1'b1;
            end
         end

         PLAY: begin
            for (int k = 0; k < 3; k++) begin
               if (active_q[k] && tick && skill_tmr_q[k] != '0) begin
                  skill_tmr_d[k] = skill_tmr_q[k] - 1'b1;
                  if (skill_tmr_q[k] == TW'(1))
                     active_d[k] = 1'b0;
               end
            end

            // Lowest-index eligible request wins; the rest are dropped.
            for (int k = 0; k < 3; k++) begin
               if (!granted && skill_req[k] && !active_q[k] && skill_q != 3'd0) begin
                  granted        = 1'b1;
                  active_d[k]    = 1'b1;
                  skill_tmr_d[k] = SKILL_T;
                  skill_d        = skill_q - 1'b1;
               end
            end

            if (bricks_clear) begin
               state_d     = STAGE_CLEAR;
               skill_d     = skill_q;
               active_d    = '0;
               skill_tmr_d = '0;
               clear_tmr_d = '0;
            end else if (ball_lost) begin
               if (life_q <= 4'd1) begin
                  life_d      = 4'd0;
                  state_d     = LOSE;
                  skill_d     = skill_q;
                  active_d    = '0;
                  skill_tmr_d = '0;
               end else begin
                  life_d = life_q - 1'b1;
               end
            end else if (pause_press) begin
               state_d = PAUSE;
            end
         end

         PAUSE: begin
            if (pause_press)
               state_d = PLAY;
         end

         STAGE_CLEAR: begin
            if (tick) begin
               if (clear_tmr_q == CLEAR_LAST) begin
                  clear_tmr_d = '0;
                  if (stage_q == LAST_STAGE) begin
                     state_d = WIN;
                  end else begin
                     state_d = PLAY;
                     stage_d = stage_q + 1'b1;
                     skill_d = SKILL_V;
                     load_d  = 1'b1;
                  end
               end else begin
                  clear_tmr_d = clear_tmr_q + 1'b1;
               end
            end
         end

         WIN, LOSE: begin
            if (start_press)
               state_d = MENU;
         end

         default: state_d = MENU;
      endcase

      run_d = (state_d == PLAY);
   end

   // LED thermometers are built from the registered counters, so they trail
   // life and skill_point by one cycle.
   always_comb begin
      led_d = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < LIVES && i < int'(life_q))
            led_d[i] = 1'b1;
         if (i >= 16 - SKILL_MAX && i >= 16 - int'(skill_q))
            led_d[i] = 1'b1;
      end
   end

   assign state        = state_q;
   assign stage_idx    = stage_q;
   assign load_stage   = load_q;
   assign run          = run_q;
   assign life         = life_q;
   assign skill_point  = skill_q;
   assign skill_active = active_q;
   assign led          = led_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
`timescale 1ns/1ps
// tb_game_flow_ctrl
// Directed bench for game_flow_ctrl with default parameters. Inputs change on
// the falling clock edge and outputs are sampled on the following falling edge.
module tb_game_flow_ctrl;

   logic        clk;
   logic        rst;
   logic        tick;
   logic        start_press;
   logic        pause_press;
   logic        ball_lost;
   logic        bricks_clear;
   logic [2:0]  skill_req;
   logic [2:0]  state;
   logic [1:0]  stage_idx;
   logic        load_stage;
   logic        run;
   logic [3:0]  life;
   logic [2:0]  skill_point;
   logic [2:0]  skill_active;
   logic [15:0] led;

   int checks = 0;
   int fails  = 0;

   game_flow_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .start_press  (start_press),
      .pause_press  (pause_press),
      .ball_lost    (ball_lost),
      .bricks_clear (bricks_clear),
      .skill_req    (skill_req),
      .state        (state),
      .stage_idx    (stage_idx),
      .load_stage   (load_stage),
      .run          (run),
      .life         (life),
      .skill_point  (skill_point),
      .skill_active (skill_active),
      .led          (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task clear_inputs();
      tick         = 1'b0;
      start_press  = 1'b0;
      pause_press  = 1'b0;
      ball_lost    = 1'b0;
      bricks_clear = 1'b0;
      skill_req    = 3'b000;
   endtask

   // Let one rising edge consume the inputs set now, then drop them.
   task drive_cycle();
      @(negedge clk);
      clear_inputs();
   endtask

   task do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         drive_cycle();
      end
   endtask

   task test_reset();
      clear_inputs();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (state !== 3'd0) begin fails++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
      checks++; if (stage_idx !== 2'd0) begin fails++; $display("[TB] FAIL reset_stage: got %0d expected 0", stage_idx); end
      checks++; if (life !== 4'd5) begin fails++; $display("[TB] FAIL reset_life: got %0d expected 5", life); end
      checks++; if (skill_point !== 3'd3) begin fails++; $display("[TB] FAIL reset_skill: got %0d expected 3", skill_point); end
      checks++; if ({skill_active, load_stage, run} !== 5'b0) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 00000", {skill_active, load_stage, run}); end
      checks++; if (led !== 16'h0000) begin fails++; $display("[TB] FAIL reset_led: got %h expected 0000", led); end
      rst = 1'b1;
      drive_cycle();
   endtask

   task test_start();
      start_press = 1'b1;
      drive_cycle();
      checks++; if (state !== 3'd1) begin fails++; $display("[TB] FAIL start_state: got %0d expected 1", state); end
      checks++; if (load_stage !== 1'b1) begin fails++; $display("[TB] FAIL start_load: got %b expected 1", load_stage); end
      checks++; if (run !== 1'b1) begin fails++; $display("[TB] FAIL start_run: got %b expected 1", run); end
      checks++; if (life !== 4'd5) begin fails++; $display("[TB] FAIL start_life: got %0d expected 5", life); end
      checks++; if (led !== 16'hE01F) begin fails++; $display("[TB] FAIL start_led: got %h expected e01f", led); end
      drive_cycle();
      checks++; if (load_stage !== 1'b0) begin fails++; $display("[TB] FAIL start_load_once: got %b expected 0", load_stage); end
   endtask

   task test_lose();
      logic [3:0] exp_life;
      for (int i = 0; i < 4; i++) begin
         exp_life = 4'(4 - i);
         ball_lost = 1'b1;
         drive_cycle();
         checks++; if (life !== exp_life) begin fails++; $display("[TB] FAIL lose_life%0d: got %0d expected %0d", i, life, exp_life); end
      end
      ball_lost = 1'b1;
      drive_cycle();
      checks++; if (state !== 3'd5) begin fails++; $display("[TB] FAIL lose_state: got %0d expected 5", state); end
      checks++; if (life !== 4'd0) begin fails++; $display("[TB] FAIL lose_life_zero: got %0d expected 0", life); end
      checks++; if (run !== 1'b0) begin fails++; $display("[TB] FAIL lose_run: got %b expected 0", run); end
      pause_press = 1'b1;
      ball_lost   = 1'b1;
      drive_cycle();
      checks++; if (state !== 3'd5 || life !== 4'd0) begin fails++; $display("[TB] FAIL lose_hold: got state %0d life %0d expected 5 0", state, life); end
      checks++; if (led !== 16'hE000) begin fails++; $display("[TB] FAIL lose_led: got %h expected e000", led); end
      start_press = 1'b1;
      drive_cycle();
      checks++; if (state !== 3'd0) begin fails++; $display("[TB] FAIL lose_to_menu: got %0d expected 0", state); end
   endtask

   task test_stage_clear();
      start_press = 1'b1;
      drive_cycle();
      checks++; if (state !== 3'd1 || life !== 4'd5) begin fails++; $display("[TB] FAIL sc_restart: got state %0d life %0d expected 1 5", state, life); end
      skill_req = 3'b001;
      drive_cycle();
      checks++; if (skill_active !== 3'b001) begin fails++; $display("[TB] FAIL sc_grant: got %b expected 001", skill_active); end
      bricks_clear = 1'b1;
      ball_lost    = 1'b1;
      drive_cycle();
      checks++; if (state !== 3'd3) begin fails++; $display("[TB] FAIL sc_enter: got %0d expected 3", state); end
      checks++; if (life !== 4'd5) begin fails++; $display("[TB] FAIL sc_life_kept: got %0d expected 5", life); end
      checks++; if (skill_active !== 3'b000 || run !== 1'b0) begin fails++; $display("[TB] FAIL sc_flags: got active %b run %b expected 000 0", skill_active, run); end
      do_ticks(39);
      checks++; if (state !== 3'd3) begin fails++; $display("[TB] FAIL sc_hold39: got %0d expected 3", state); end
      do_ticks(1);
      checks++; if (state !== 3'd1 || stage_idx !== 2'd1) begin fails++; $display("[TB] FAIL sc_next: got state %0d stage %0d expected 1 1", state, stage_idx); end
      checks++; if (skill_point !== 3'd3 || load_stage !== 1'b1) begin fails++; $display("[TB] FAIL sc_reload: got skill %0d load %b expected 3 1", skill_point, load_stage); end
      drive_cycle();
      checks++; if (load_stage !== 1'b0) begin fails++; $display("[TB] FAIL sc_load_once: got %b expected 0", load_stage); end
      bricks_clear = 1'b1;
      drive_cycle();
      do_ticks(40);
      checks++; if (state !== 3'd1 || stage_idx !== 2'd2) begin fails++; $display("[TB] FAIL sc_stage2: got state %0d stage %0d expected 1 2", state, stage_idx); end
      bricks_clear = 1'b1;
      drive_cycle();
      do_ticks(40);
      checks++; if (state !== 3'd4 || stage_idx !== 2'd2) begin fails++; $display("[TB] FAIL sc_win: got state %0d stage %0d expected 4 2", state, stage_idx); end
      checks++; if (run !== 1'b0 || load_stage !== 1'b0) begin fails++; $display("[TB] FAIL sc_win_flags: got run %b load %b expected 0 0", run, load_stage); end
      start_press = 1'b1;
      drive_cycle();
      checks++; if (state !== 3'd0) begin fails++; $display("[TB] FAIL sc_win_menu: got %0d expected 0", state); end
   endtask

   task test_skills();
      start_press = 1'b1;
      drive_cycle();
      checks++; if (stage_idx !== 2'd0 || skill_point !== 3'd3) begin fails++; $display("[TB] FAIL sk_restart: got stage %0d skill %0d expected 0 3", stage_idx, skill_point); end
      skill_req = 3'b011;
      drive_cycle();
      checks++; if (skill_active !== 3'b001 || skill_point !== 3'd2) begin fails++; $display("[TB] FAIL sk_arbitrate: got active %b skill %0d expected 001 2", skill_active, skill_point); end
      skill_req = 3'b001;
      drive_cycle();
      checks++; if (skill_active !== 3'b001 || skill_point !== 3'd2) begin fails++; $display("[TB] FAIL sk_repeat: got active %b skill %0d expected 001 2", skill_active, skill_point); end
      do_ticks(99);
      checks++; if (skill_active !== 3'b001) begin fails++; $display("[TB] FAIL sk_tick99: got %b expected 001", skill_active); end
      do_ticks(1);
      checks++; if (skill_active !== 3'b000 || skill_point !== 3'd2) begin fails++; $display("[TB] FAIL sk_expire: got active %b skill %0d expected 000 2", skill_active, skill_point); end
      checks++; if (led !== 16'hC01F) begin fails++; $display("[TB] FAIL sk_led: got %h expected c01f", led); end
   endtask

   task test_pause();
      skill_req = 3'b100;
      drive_cycle();
      checks++; if (skill_active !== 3'b100 || skill_point !== 3'd1) begin fails++; $display("[TB] FAIL pa_grant: got active %b skill %0d expected 100 1", skill_active, skill_point); end
      do_ticks(10);
      pause_press = 1'b1;
      drive_cycle();
      checks++; if (state !== 3'd2 || run !== 1'b0) begin fails++; $display("[TB] FAIL pa_enter: got state %0d run %b expected 2 0", state, run); end
      do_ticks(50);
      ball_lost   = 1'b1;
      skill_req   = 3'b001;
      start_press = 1'b1;
      drive_cycle();
      checks++; if (state !== 3'd2 || life !== 4'd5) begin fails++; $display("[TB] FAIL pa_ignore: got state %0d life %0d expected 2 5", state, life); end
      checks++; if (skill_active !== 3'b100 || skill_point !== 3'd1) begin fails++; $display("[TB] FAIL pa_frozen: got active %b skill %0d expected 100 1", skill_active, skill_point); end
      pause_press = 1'b1;
      drive_cycle();
      checks++; if (state !== 3'd1 || run !== 1'b1) begin fails++; $display("[TB] FAIL pa_resume: got state %0d run %b expected 1 1", state, run); end
      do_ticks(89);
      checks++; if (skill_active !== 3'b100) begin fails++; $display("[TB] FAIL pa_remaining: got %b expected 100", skill_active); end
      do_ticks(1);
      checks++; if (skill_active !== 3'b000) begin fails++; $display("[TB] FAIL pa_expire: got %b expected 000", skill_active); end
   endtask

   task test_reset_mid_clear();
      bricks_clear = 1'b1;
      drive_cycle();
      do_ticks(40);
      checks++; if (stage_idx !== 2'd1 || state !== 3'd1) begin fails++; $display("[TB] FAIL rm_stage1: got state %0d stage %0d expected 1 1", state, stage_idx); end
      bricks_clear = 1'b1;
      ball_lost    = 1'b1;
      drive_cycle();
      do_ticks(10);
      checks++; if (state !== 3'd3) begin fails++; $display("[TB] FAIL rm_in_clear: got %0d expected 3", state); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (state !== 3'd0 || stage_idx !== 2'd0) begin fails++; $display("[TB] FAIL rm_async: got state %0d stage %0d expected 0 0", state, stage_idx); end
      checks++; if (life !== 4'd5 || skill_point !== 3'd3) begin fails++; $display("[TB] FAIL rm_counters: got life %0d skill %0d expected 5 3", life, skill_point); end
      checks++; if ({skill_active, load_stage, run} !== 5'b0 || led !== 16'h0) begin fails++; $display("[TB] FAIL rm_outputs: got flags %b led %h expected 00000 0000", {skill_active, load_stage, run}, led); end
      @(negedge clk);
      rst = 1'b1;
      drive_cycle();
      checks++; if (state !== 3'd0) begin fails++; $display("[TB] FAIL rm_after: got %0d expected 0", state); end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      test_reset();
      test_start();
      test_lose();
      test_stage_clear();
      test_skills();
      test_pause();
      test_reset_mid_clear();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
